mdu_param: RTL

MDU_PARAM -- requirements
Module: mdu_param

---
 rtl/mdu_param_pkg.sv | 35 +++
 rtl/mdu_latency_ctr.sv | 32 +++
 rtl/mdu_param.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/mdu_param_pkg.sv
// Shared definitions for the multiply/divide unit: op encoding, default
// latencies and the sequencing FSM state type.
package mdu_param_pkg;

  localparam int unsigned OP_W = 4;

  localparam logic [OP_W-1:0] OP_NOP   = 4'd0;
  localparam logic [OP_W-1:0] OP_MULT  = 4'd1;
  localparam logic [OP_W-1:0] OP_MULTU = 4'd2;
  localparam logic [OP_W-1:0] OP_DIV   = 4'd3;
  localparam logic [OP_W-1:0] OP_DIVU  = 4'd4;
  localparam logic [OP_W-1:0] OP_MADD  = 4'd5;
  localparam logic [OP_W-1:0] OP_MADDU = 4'd6;
  localparam logic [OP_W-1:0] OP_MSUB  = 4'd7;
  localparam logic [OP_W-1:0] OP_MSUBU = 4'd8;
  localparam logic [OP_W-1:0] OP_MTHI  = 4'd9;
  localparam logic [OP_W-1:0] OP_MTLO  = 4'd10;

  localparam int unsigned MUL_LAT_DEF = 5;
  localparam int unsigned DIV_LAT_DEF = 10;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  function automatic logic is_mul_class(input logic [OP_W-1:0] op);
    return op inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
  endfunction

  function automatic logic is_div_class(input logic [OP_W-1:0] op);
    return op inside {OP_DIV, OP_DIVU};
  endfunction

endpackage

// File: rtl/mdu_latency_ctr.sv
// Loadable down-counter that times a multiply/divide; done_c marks the
// final busy cycle (count == 1).
module mdu_latency_ctr
  import mdu_param_pkg::*;
#(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             clear,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             done_c
);

  // Counter parks at zero when idle; clear wins over load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign done_c = (count == CNT_W'(1));

endmodule

// File: rtl/mdu_param.sv
// MIPS-style HI/LO multiply/divide unit: the result is computed at start,
// held pending for the configured latency, then committed to HI/LO.
module mdu_param
  import mdu_param_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned MUL_LAT = MUL_LAT_DEF,
  parameter int unsigned DIV_LAT = DIV_LAT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [3:0]       op,
  input  logic             start,
  input  logic             flush,
  output logic             busy,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);
  localparam int unsigned DW      = 2 * WIDTH;

  if (!(WIDTH == 16 || WIDTH == 32 || WIDTH == 64)) begin : g_bad_width
    $error("mdu_param: WIDTH must be 16, 32 or 64");
  end
  if (MUL_LAT < 1 || DIV_LAT < 1) begin : g_bad_lat
    $error("mdu_param: MUL_LAT and DIV_LAT must be at least 1");
  end

  state_t          state;
  logic [DW-1:0]   pending;
  logic [DW-1:0]   result;
  logic [CNT_W-1:0] count;
  logic            done_c;
  logic            long_op;
  logic            accept;

  logic            mul_signed;
  logic [DW-1:0]   a_ext;
  logic [DW-1:0]   b_ext;
  logic [DW-1:0]   prod;
  logic [DW-1:0]   acc;
  logic            a_neg;
  logic            b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] q_mag;
  logic [WIDTH-1:0] r_mag;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;

  assign long_op = is_mul_class(op) || is_div_class(op);
  assign accept  = (state == S_IDLE) && start && !flush;

  // Single shared multiplier and magnitude divider; signedness is handled
  // by extension for multiply and by sign fix-up for divide.
  always_comb begin
    mul_signed = op inside {OP_MULT, OP_MADD, OP_MSUB};
    a_ext      = mul_signed ? {{WIDTH{in1[WIDTH-1]}}, in1} : {{WIDTH{1'b0}}, in1};
    b_ext      = mul_signed ? {{WIDTH{in2[WIDTH-1]}}, in2} : {{WIDTH{1'b0}}, in2};
    prod       = a_ext * b_ext;
    acc        = {hi_out, lo_out};

    a_neg = (op == OP_DIV) && in1[WIDTH-1];
    b_neg = (op == OP_DIV) && in2[WIDTH-1];
    a_mag = a_neg ? -in1 : in1;
    b_mag = b_neg ? -in2 : in2;
    q_mag = (b_mag == '0) ? '0 : a_mag / b_mag;
    r_mag = (b_mag == '0) ? '0 : a_mag % b_mag;
    // Most-negative / -1 wraps back to most-negative with zero remainder.
    quo   = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem   = a_neg ? -r_mag : r_mag;

    result = acc;
    case (op)
      OP_MULT, OP_MULTU: result = prod;
      OP_MADD, OP_MADDU: result = acc + prod;
      OP_MSUB, OP_MSUBU: result = acc - prod;
      OP_DIV, OP_DIVU:   result = (in2 == '0) ? {in1, {WIDTH{1'b1}}} : {rem, quo};
      default:           result = acc;
    endcase
  end

  mdu_latency_ctr #(
    .CNT_W (CNT_W)
  ) u_ctr (
    .clk      (clk),
    .reset    (reset),
    .load     (accept && long_op),
    .clear    (flush),
    .load_val (is_div_class(op) ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT)),
    .count    (count),
    .done_c   (done_c)
  );

  // Sequencing FSM; flush outranks both start and completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      pending <= '0;
      hi_out  <= '0;
      lo_out  <= '0;
    end else if (flush) begin
      if (state == S_RUN) begin
        state   <= S_IDLE;
        busy    <= 1'b0;
        pending <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (long_op) begin
              pending <= result;
              state   <= S_RUN;
              busy    <= 1'b1;
            end else if (op == OP_MTHI) begin
              hi_out <= in1;
            end else if (op == OP_MTLO) begin
              lo_out <= in1;
            end
          end
        end
        S_RUN: begin
          if (done_c) begin
            hi_out <= pending[DW-1:WIDTH];
            lo_out <= pending[WIDTH-1:0];
            state  <= S_IDLE;
            busy   <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
